ram_bus_master: RTL and testbench

//  Initiator for the single-port cs/we/oe RAM with a shared tri-state data bus.

---
 rtl/ram_master_pkg.sv | 8 +
 rtl/ram_burst_ctr.sv | 43 ++++
 rtl/ram_bus_master.sv | 122 ++++++++++++
 tb/tb_ram_bus_master.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_master_pkg.sv
// Shared types and default widths for the cs/we/oe RAM bus master.
package ram_master_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 4;
endpackage

// File: rtl/ram_burst_ctr.sv
// Burst address/beat counter: next beat address (wrapping) and last flag.
module ram_burst_ctr
  import ram_master_pkg::*;
#(
  parameter int AW = ADDR_W_DEF,
  parameter int LW = LEN_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          issue_i,
  input  logic [AW-1:0] addr_i,
  input  logic [LW-1:0] len_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);
  localparam logic [AW-1:0] A_ONE = AW'(1);
  localparam logic [LW-1:0] L_ONE = LW'(1);

  logic [AW-1:0] addr_q;
  logic [LW-1:0] rem_q;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] base_rem;

  // A load that also issues uses the request fields directly
  assign base_addr = load_i ? addr_i : addr_q;
  assign base_rem  = load_i ? len_i : rem_q;
  assign addr_o    = base_addr;
  assign last_o    = (base_rem == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else if (issue_i) begin
      addr_q <= base_addr + A_ONE;
      rem_q  <= base_rem - L_ONE;
    end else if (load_i) begin
      addr_q <= addr_i;
      rem_q  <= len_i;
    end
  end
endmodule

// File: rtl/ram_bus_master.sv
// Burst initiator for a single-port cs/we/oe RAM with tri-state data bus.
// Build option TURNAROUND_GAP_EN inserts one idle cycle between write and read.
module ram_bus_master
  import ram_master_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int LEN_WIDTH  = LEN_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  done,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe
);
  state_t state_q;
  op_t    req_op;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic cs_q, we_q, oe_q, last_q;
  logic rd_valid_q, rd_last_q;

  logic accept, gap, rd_now, wr_now, issue;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic beat_last;

  assign req_op    = req_we ? OP_WR : OP_RD;
  assign req_ready = rst_n && (state_q == IDLE);
  assign wr_ready  = (state_q == WR);
  assign busy      = (state_q != IDLE);
  assign accept    = req_valid && req_ready;

`ifdef TURNAROUND_GAP_EN
  assign gap = we_q;
`else
  assign gap = 1'b0;
`endif

  assign rd_now = (state_q == RD) ||
                  (accept && req_op == OP_RD && !gap);
  assign wr_now = (state_q == WR) && wr_valid;
  assign issue  = rd_now || wr_now;

  ram_burst_ctr #(
    .AW(ADDR_WIDTH),
    .LW(LEN_WIDTH)
  ) u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .issue_i(issue),
    .addr_i (req_addr),
    .len_i  (req_len),
    .addr_o (beat_addr),
    .last_o (beat_last)
  );

  // Only the master drives during write beats; RAM drives on we=0 & oe=1
  assign ram_data = we_q ? wdata_q : {DATA_WIDTH{1'bz}};

  assign ram_addr = addr_q;
  assign ram_cs   = cs_q;
  assign ram_we   = we_q;
  assign ram_oe   = oe_q;
  assign done     = last_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign rd_data  = rd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      cs_q       <= 1'b0;
      we_q       <= 1'b0;
      oe_q       <= 1'b0;
      last_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      cs_q   <= issue;
      we_q   <= wr_now;
      oe_q   <= rd_now;
      last_q <= issue && beat_last;
      if (issue) addr_q <= beat_addr;
      if (wr_now) wdata_q <= wr_data;
      rd_valid_q <= cs_q && oe_q;
      rd_last_q  <= cs_q && oe_q && last_q;
      if (cs_q && oe_q) rd_data_q <= ram_data;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (req_op == OP_WR) state_q <= WR;
            else if (!(rd_now && beat_last)) state_q <= RD;
          end
        end
        RD: if (beat_last) state_q <= IDLE;
        WR: if (wr_now && beat_last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_bus_master.sv
// Scoreboard bench for ram_bus_master with a cs/we/oe RAM model.
module tb_ram_bus_master;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int LW = 4;
`ifdef TURNAROUND_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  typedef struct {
    logic [DW-1:0] d;
    int last;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic rd_valid, rd_last, done, busy;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;
  logic ram_cs, ram_we, ram_oe;

  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] exp_mem [1<<AW];
  logic [DW-1:0] ram_q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int overlap = 0;
  int last_we_cyc = 0;
  int ta_gap = -1;
  bit we_seen = 1'b0;
  bit just_wrote = 1'b0;
  int wbeats[$];
  exp_t sbq[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  ram_bus_master dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_len  (req_len),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .done     (done),
    .busy     (busy),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_oe   (ram_oe)
  );

  // RAM model: write commits at posedge, read latches on negedge
  always @(posedge clk)
    if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
  always @(negedge clk)
    if (ram_cs && !ram_we && ram_oe) ram_q <= mem[ram_addr];
  assign ram_data = (ram_cs && !ram_we && ram_oe) ? ram_q : 'z;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: bus rules and read scoreboard
  always @(negedge clk) begin
    if (ram_we && ram_oe) overlap++;
    if (done) done_cnt++;
    if (ram_cs && ram_we) begin
      wbeats.push_back(cyc);
      last_we_cyc = cyc;
      we_seen = 1'b1;
    end
    if (ram_cs && ram_oe && we_seen) begin
      ta_gap = cyc - last_we_cyc - 1;
      we_seen = 1'b0;
    end
    if (rd_valid) begin
      if (sbq.size() == 0) begin
        chk("rd_unexpected", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("rd_data", int'(rd_data), int'(mon_e.d));
        chk("rd_last", int'(rd_last), mon_e.last);
        chk("rd_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic wait_ready(output int hc);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    hc = cyc;
  endtask

  task automatic do_write(input logic [AW-1:0] a,
                          input logic [DW-1:0] d [4],
                          input int nb, input int stall_at);
    int hc;
    int n;
    req_we = 1'b1;
    req_addr = a;
    req_len = LW'(nb - 1);
    req_valid = 1'b1;
    wait_ready(hc);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (i == stall_at) begin
        wr_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
      end
      wr_valid = 1'b1;
      wr_data = d[i];
      n = 0;
      while (!wr_ready && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (!wr_ready) chk("wr_ready_timeout", 0, 1);
      @(posedge clk); #1;
      exp_mem[AW'(int'(a) + i)] = d[i];
    end
    wr_valid = 1'b0;
    just_wrote = 1'b1;
  endtask

  task automatic do_read(input logic [AW-1:0] a,
                         input logic [LW-1:0] len);
    int hc;
    int lat;
    exp_t e;
    lat = (GAP != 0 && just_wrote) ? 3 : 2;
    req_we = 1'b0;
    req_addr = a;
    req_len = len;
    req_valid = 1'b1;
    wait_ready(hc);
    for (int i = 0; i <= int'(len); i++) begin
      e.d = exp_mem[AW'(int'(a) + i)];
      e.last = (i == int'(len)) ? 1 : 0;
      e.cyc = hc + lat + i;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    just_wrote = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_len = '0;
    wr_valid = 1'b0;
    wr_data = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = DW'(i * 7 + 3);
      exp_mem[i] = DW'(i * 7 + 3);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_bus", int'({ram_cs, ram_we, ram_oe}), 0);
    chk("rst_addr", int'(ram_addr), 0);
    chk("rst_rd", int'({rd_valid, rd_last, done}), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", int'(req_ready), 1);

    // Reset in the middle of an 8-beat read
    d0 = done_cnt;
    do_read(12'h010, 4'd7);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("midrst_bus", int'({ram_cs, ram_we, ram_oe}), 0);
    chk("midrst_addr", int'(ram_addr), 0);
    chk("midrst_rd", int'({rd_valid, done, busy}), 0);
    chk("midrst_req_ready", int'(req_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_release_ready", int'(req_ready), 1);
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt - d0, 0);

    // Single write then back-to-back single read
    d0 = done_cnt;
    do_write(12'h123, '{8'hA5, 8'h00, 8'h00, 8'h00}, 1, -1);
    do_read(12'h123, 4'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("single_mem", int'(mem[12'h123]), 'hA5);
    chk("single_done", done_cnt - d0, 2);
    chk("single_turnaround", ta_gap, GAP);

    // Wrapping write burst and read back
    d0 = done_cnt;
    wbeats.delete();
    do_write(12'hFFE, '{8'h11, 8'h22, 8'h33, 8'h44}, 4, -1);
    do_read(12'hFFE, 4'd3);
    repeat (8) @(posedge clk);
    #1;
    chk("wrap_beats", wbeats.size(), 4);
    chk("wrap_mem_ffe", int'(mem[12'hFFE]), 'h11);
    chk("wrap_mem_fff", int'(mem[12'hFFF]), 'h22);
    chk("wrap_mem_000", int'(mem[12'h000]), 'h33);
    chk("wrap_mem_001", int'(mem[12'h001]), 'h44);
    chk("wrap_done", done_cnt - d0, 2);
    chk("wrap_turnaround", ta_gap, GAP);

    // Write burst with two stalled cycles
    d0 = done_cnt;
    wbeats.delete();
    do_write(12'h200, '{8'h55, 8'h66, 8'h77, 8'h88}, 4, 2);
    do_read(12'h200, 4'd3);
    repeat (8) @(posedge clk);
    #1;
    chk("stall_beats", wbeats.size(), 4);
    if (wbeats.size() == 4)
      chk("stall_idle", wbeats[3] - wbeats[0] + 1 - 4, 2);
    chk("stall_mem_200", int'(mem[12'h200]), 'h55);
    chk("stall_mem_203", int'(mem[12'h203]), 'h88);
    chk("stall_done", done_cnt - d0, 2);

    chk("sb_empty", sbq.size(), 0);
    chk("bus_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
